multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-002 The block SHALL have port Instruction, input, 32 bits: current IR contents, stable from DECODE until return to FETCH.
REQ-003 The block SHALL have port MemReady, input, 1 bit: memory handshake, access completes in any cycle it is 1 while a request is held.
REQ-004 The block SHALL have port BranchTaken, input, 1 bit: branch condition result from the ALU, valid in EXEC.
REQ-005 The block SHALL have the following 1-bit outputs: IRWrite, PCWrite, IorD (0=PC address, 1=ALU address), MemRead, MemWrite, RegWrite, MemtoReg, RegDst, ALUSrcA, ALUSrcB, IllegalInstr, InstrRetired.
REQ-006 The block SHALL have output PCSrc, 2 bits: 00 PC+4, 01 branch target, 10 jump target, 11 register (JR).
REQ-007 The block SHALL have output ALUCode, 5 bits: ALU operation, combinational from Instruction using the existing ALU code set.
REQ-008 The block SHALL have outputs State (3 bits, current FSM state) and RetiredCount (32 bits, instructions completed).

Function
REQ-009 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL transition to FETCH.
REQ-010 FETCH SHALL hold MemRead=1 and IorD=0 until MemReady=1. In that cycle it SHALL pulse IRWrite=1 and PCWrite=1 with PCSrc=00, then go to DECODE.
REQ-011 DECODE SHALL last exactly one cycle. Next state: J gives PCWrite=1, PCSrc=10, FETCH. JR gives PCWrite=1, PCSrc=11, FETCH. Branch, R-type, I-type, LW or SW gives EXEC. Instruction==0 (NOP) gives FETCH. Any other encoding gives FETCH with a one-cycle IllegalInstr pulse.
REQ-012 EXEC for a branch SHALL assert PCWrite=BranchTaken with PCSrc=01, then go to FETCH. EXEC for LW or SW SHALL go to MEM. EXEC for R/I-type SHALL go to WB.
REQ-013 MEM SHALL hold IorD=1 with MemRead=1 (LW) or MemWrite=1 (SW) until MemReady=1. On ready, LW SHALL go to WB and SW SHALL go to FETCH.
REQ-014 WB SHALL assert RegWrite=1 for exactly one cycle, with MemtoReg=1 for LW only and RegDst=1 for R-type only, then go to FETCH.
REQ-015 ALUSrcA SHALL be 1 for SLL/SRL/SRA. ALUSrcB SHALL be 1 for I-type, LW and SW. Both SHALL be valid in EXEC and WB.
REQ-016 InstrRetired SHALL pulse exactly one cycle on the final cycle of each legal instruction, including NOP. RetiredCount SHALL increment by 1 in the same cycle and wrap from 0xFFFFFFFF to 0.
REQ-017 Zero-wait-state latencies SHALL be: J/JR 2 cycles, branch 3, R/I-type 4, SW 4, LW 5. Each memory wait cycle SHALL add one cycle.
REQ-018 MemReady asserted outside FETCH/MEM SHALL be ignored. At most one of MemRead and MemWrite SHALL be 1 in any cycle.
REQ-019 All strobes (IRWrite, PCWrite, RegWrite, MemWrite, IllegalInstr, InstrRetired) SHALL be Moore/Mealy outputs of the current state and inputs only, with no registered delay.

Reset
REQ-020 While rst_n=0, the FSM SHALL be in state FETCH, RetiredCount SHALL be 0 and all strobes SHALL be 0. MemRead SHALL be 0 during reset and SHALL be 1 from the first cycle after release.
REQ-021 Reset asserted mid-MEM SHALL drop MemWrite and MemRead immediately (asynchronously), with no partial register write.

Structure
REQ-022 The shared package mips_defs SHALL hold the opcode/funct constants, the ALUCode values, the PCSrc encodings and the FSM state codes.
REQ-023 A combinational sub-module insn_class SHALL classify Instruction into R1, R2, JR, J, Branch, I-type, LW, SW, NOP and Illegal, and SHALL produce ALUCode. The FSM and RetiredCount SHALL reside in multicycle_ctrl.

Verification
REQ-024 ADD 0x00221820 with MemReady held 1 -> states FETCH,DECODE,EXEC,WB; RegWrite=1 and RegDst=1 in cycle 4; ALUCode=00000; RetiredCount 0->1.
REQ-025 LW 0x8C240008, MemReady low for 2 MEM cycles -> MEM lasts 3 cycles with MemRead=1, IorD=1; then WB with MemtoReg=1; total 7 cycles.
REQ-026 BEQ 0x10220004 with BranchTaken=0, then repeated with BranchTaken=1 -> PCWrite=0 in EXEC, then PCWrite=1 with PCSrc=01; 3 cycles each; ALUCode=01010.
REQ-027 J 0x08000010 -> PCWrite=1 with PCSrc=10 in DECODE; back in FETCH on cycle 3. 0xFC000000 -> IllegalInstr pulse; RetiredCount unchanged.
REQ-028 SW 0xAC240008 with rst_n dropped during the MEM wait -> MemWrite=0 in the same cycle; State=0; RegWrite never asserted; MemRead=1 from the first cycle after release.
REQ-029 RetiredCount preloaded via force to 0xFFFFFFFF, then one NOP -> count wraps to 0 with InstrRetired=1.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcode/funct fields,
// ALU operation codes, PC source selects, FSM state codes and instruction classes.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDU = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SUB  = 5'd10;
  localparam logic [4:0] ALU_SUBU = 5'd11;
  localparam logic [4:0] ALU_SRA  = 5'd12;
  localparam logic [4:0] ALU_SLLV = 5'd13;
  localparam logic [4:0] ALU_SRLV = 5'd14;
  localparam logic [4:0] ALU_SRAV = 5'd15;
  localparam logic [4:0] ALU_LUI  = 5'd16;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // R1 = shift by immediate shamt, R2 = every other register-register ALU op.
  typedef enum logic [3:0] {
    CLS_R1  = 4'd0,
    CLS_R2  = 4'd1,
    CLS_JR  = 4'd2,
    CLS_J   = 4'd3,
    CLS_BR  = 4'd4,
    CLS_I   = 4'd5,
    CLS_LW  = 4'd6,
    CLS_SW  = 4'd7,
    CLS_NOP = 4'd8,
    CLS_ILL = 4'd9
  } insn_cls_t;

  function automatic logic is_rtype(input insn_cls_t cls);
    return (cls == CLS_R1) || (cls == CLS_R2);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_insn_class.sv
// Combinational instruction classifier: maps the IR contents to an instruction
// class for the control FSM and to the ALU operation code.
module insn_class
  import mips_defs::*;
(
  input  logic [31:0] Instruction,
  output insn_cls_t   cls_o,
  output logic [4:0]  alu_code_o
);

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [4:0]  rs_s;
  logic [4:0]  shamt_s;
  logic [14:0] jr_zero_s;
  insn_cls_t   r1_cls_s;
  insn_cls_t   r2_cls_s;
  insn_cls_t   raw_cls_s;

  assign opcode_s  = Instruction[31:26];
  assign funct_s   = Instruction[5:0];
  assign rs_s      = Instruction[25:21];
  assign shamt_s   = Instruction[10:6];
  assign jr_zero_s = Instruction[20:6];

  // Unused register fields must be zero, otherwise the encoding is treated as illegal.
  assign r1_cls_s = (rs_s == 5'd0) ? CLS_R1 : CLS_ILL;
  assign r2_cls_s = (shamt_s == 5'd0) ? CLS_R2 : CLS_ILL;

  always_comb begin
    raw_cls_s  = CLS_ILL;
    alu_code_o = ALU_ADD;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          F_SLL:  begin raw_cls_s = r1_cls_s; alu_code_o = ALU_SLL;  end
          F_SRL:  begin raw_cls_s = r1_cls_s; alu_code_o = ALU_SRL;  end
          F_SRA:  begin raw_cls_s = r1_cls_s; alu_code_o = ALU_SRA;  end
          F_SLLV: begin raw_cls_s = r2_cls_s; alu_code_o = ALU_SLLV; end
          F_SRLV: begin raw_cls_s = r2_cls_s; alu_code_o = ALU_SRLV; end
          F_SRAV: begin raw_cls_s = r2_cls_s; alu_code_o = ALU_SRAV; end
          F_JR:   raw_cls_s = (jr_zero_s == 15'd0) ? CLS_JR : CLS_ILL;
          F_ADD:  begin raw_cls_s = r2_cls_s; alu_code_o = ALU_ADD;  end
          F_ADDU: begin raw_cls_s = r2_cls_s; alu_code_o = ALU_ADDU; end
          F_SUB:  begin raw_cls_s = r2_cls_s; alu_code_o = ALU_SUB;  end
          F_SUBU: begin raw_cls_s = r2_cls_s; alu_code_o = ALU_SUBU; end
          F_AND:  begin raw_cls_s = r2_cls_s; alu_code_o = ALU_AND;  end
          F_OR:   begin raw_cls_s = r2_cls_s; alu_code_o = ALU_OR;   end
          F_XOR:  begin raw_cls_s = r2_cls_s; alu_code_o = ALU_XOR;  end
          F_NOR:  begin raw_cls_s = r2_cls_s; alu_code_o = ALU_NOR;  end
          F_SLT:  begin raw_cls_s = r2_cls_s; alu_code_o = ALU_SLT;  end
          F_SLTU: begin raw_cls_s = r2_cls_s; alu_code_o = ALU_SLTU; end
          default: raw_cls_s = CLS_ILL;
        endcase
      end
      OP_J:              raw_cls_s = CLS_J;
      OP_BEQ, OP_BNE:    begin raw_cls_s = CLS_BR; alu_code_o = ALU_SUB;  end
      OP_ADDI:           begin raw_cls_s = CLS_I;  alu_code_o = ALU_ADD;  end
      OP_ADDIU:          begin raw_cls_s = CLS_I;  alu_code_o = ALU_ADDU; end
      OP_SLTI:           begin raw_cls_s = CLS_I;  alu_code_o = ALU_SLT;  end
      OP_SLTIU:          begin raw_cls_s = CLS_I;  alu_code_o = ALU_SLTU; end
      OP_ANDI:           begin raw_cls_s = CLS_I;  alu_code_o = ALU_AND;  end
      OP_ORI:            begin raw_cls_s = CLS_I;  alu_code_o = ALU_OR;   end
      OP_XORI:           begin raw_cls_s = CLS_I;  alu_code_o = ALU_XOR;  end
      OP_LUI:            begin raw_cls_s = CLS_I;  alu_code_o = ALU_LUI;  end
      OP_LW:             begin raw_cls_s = CLS_LW; alu_code_o = ALU_ADD;  end
      OP_SW:             begin raw_cls_s = CLS_SW; alu_code_o = ALU_ADD;  end
      default:           raw_cls_s = CLS_ILL;
    endcase
  end

  // The all-zero word decodes as SLL r0 but is retired as a plain NOP.
  assign cls_o = (Instruction == 32'd0) ? CLS_NOP : raw_cls_s;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with combinational
// strobes and a free-running retired-instruction counter.
module multicycle_ctrl
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instruction,
  input  logic        MemReady,
  input  logic        BranchTaken,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic        IllegalInstr,
  output logic        InstrRetired,
  output logic [1:0]  PCSrc,
  output logic [4:0]  ALUCode,
  output logic [2:0]  State,
  output logic [31:0] RetiredCount
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] retired_count_q;
  logic [31:0] retired_count_d;
  insn_cls_t   cls_s;

  logic ir_write_s;
  logic pc_write_s;
  logic iord_s;
  logic mem_read_s;
  logic mem_write_s;
  logic reg_write_s;
  logic memtoreg_s;
  logic reg_dst_s;
  logic illegal_s;
  logic retire_s;
  logic [1:0] pc_src_s;

  insn_class u_insn_class (
    .Instruction (Instruction),
    .cls_o       (cls_s),
    .alu_code_o  (ALUCode)
  );

  always_comb begin
    state_d     = state_q;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    iord_s      = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    memtoreg_s  = 1'b0;
    reg_dst_s   = 1'b0;
    illegal_s   = 1'b0;
    retire_s    = 1'b0;
    pc_src_s    = PCSRC_PC4;
    case (state_q)
      ST_FETCH: begin
        mem_read_s = 1'b1;
        if (MemReady) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = ST_DECODE;
        end else begin
          state_d    = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (cls_s)
          CLS_J: begin
            pc_write_s = 1'b1;
            pc_src_s   = PCSRC_JUMP;
            retire_s   = 1'b1;
            state_d    = ST_FETCH;
          end
          CLS_JR: begin
            pc_write_s = 1'b1;
            pc_src_s   = PCSRC_REG;
            retire_s   = 1'b1;
            state_d    = ST_FETCH;
          end
          CLS_NOP: begin
            retire_s = 1'b1;
            state_d  = ST_FETCH;
          end
          CLS_BR, CLS_R1, CLS_R2, CLS_I, CLS_LW, CLS_SW: state_d = ST_EXEC;
          default: begin
            illegal_s = 1'b1;
            state_d   = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: begin
        case (cls_s)
          CLS_BR: begin
            pc_write_s = BranchTaken;
            pc_src_s   = PCSRC_BRANCH;
            retire_s   = 1'b1;
            state_d    = ST_FETCH;
          end
          CLS_LW, CLS_SW:        state_d = ST_MEM;
          CLS_R1, CLS_R2, CLS_I: state_d = ST_WB;
          default:               state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        iord_s = 1'b1;
        case (cls_s)
          CLS_LW: begin
            mem_read_s = 1'b1;
            state_d    = MemReady ? ST_WB : ST_MEM;
          end
          CLS_SW: begin
            mem_write_s = 1'b1;
            retire_s    = MemReady;
            state_d     = MemReady ? ST_FETCH : ST_MEM;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_WB: begin
        reg_write_s = 1'b1;
        memtoreg_s  = (cls_s == CLS_LW);
        reg_dst_s   = is_rtype(cls_s);
        retire_s    = 1'b1;
        state_d     = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    retired_count_d = retired_count_q + (retire_s ? 32'd1 : 32'd0);
  end

  // State and retirement counter; reset forces FETCH and clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_FETCH;
      retired_count_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      retired_count_q <= retired_count_d;
    end
  end

  // Gating with rst_n kills memory requests and strobes the instant reset asserts.
  assign IRWrite      = ir_write_s  & rst_n;
  assign PCWrite      = pc_write_s  & rst_n;
  assign IorD         = iord_s      & rst_n;
  assign MemRead      = mem_read_s  & rst_n;
  assign MemWrite     = mem_write_s & rst_n;
  assign RegWrite     = reg_write_s & rst_n;
  assign MemtoReg     = memtoreg_s  & rst_n;
  assign RegDst       = reg_dst_s   & rst_n;
  assign IllegalInstr = illegal_s   & rst_n;
  assign InstrRetired = retire_s    & rst_n;
  assign PCSrc        = pc_src_s;
  assign ALUSrcA      = (cls_s == CLS_R1);
  assign ALUSrcB      = (cls_s == CLS_I) || (cls_s == CLS_LW) || (cls_s == CLS_SW);
  assign State        = state_q;
  assign RetiredCount = retired_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-instruction cycle-trace model is
// expanded from the instruction class and memory wait counts, then compared each cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Instruction = 32'd0;
  logic        MemReady = 1'b0;
  logic        BranchTaken = 1'b0;
  logic        IRWrite, PCWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg, RegDst;
  logic        ALUSrcA, ALUSrcB, IllegalInstr, InstrRetired;
  logic [1:0]  PCSrc;
  logic [4:0]  ALUCode;
  logic [2:0]  State;
  logic [31:0] RetiredCount;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Instruction(Instruction), .MemReady(MemReady),
    .BranchTaken(BranchTaken), .IRWrite(IRWrite), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IllegalInstr(IllegalInstr),
    .InstrRetired(InstrRetired), .PCSrc(PCSrc), .ALUCode(ALUCode), .State(State),
    .RetiredCount(RetiredCount)
  );

  localparam int K_R1 = 0, K_R2 = 1, K_JR = 2, K_J = 3, K_BR = 4;
  localparam int K_I = 5, K_LW = 6, K_SW = 7, K_NOP = 8, K_ILL = 9;

  typedef struct {
    logic [2:0] st;
    logic irw, pcw;
    logic [1:0] pcsrc;
    logic iord, mrd, mwr, rw, m2r, rdst, asa, asb, ill, ret, mr;
    logic [4:0] alu;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] model_cnt = 32'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, got, want);
    end
  endtask

  function automatic exp_t base(input logic [2:0] st, input int kind, input logic [4:0] alu,
                                input logic mr);
    exp_t e;
    e = '{st: st, irw: 1'b0, pcw: 1'b0, pcsrc: 2'b00, iord: 1'b0, mrd: 1'b0, mwr: 1'b0,
          rw: 1'b0, m2r: 1'b0, rdst: 1'b0, asa: 1'b0, asb: 1'b0, ill: 1'b0, ret: 1'b0,
          mr: mr, alu: alu};
    e.asa = (kind == K_R1);
    e.asb = (kind == K_I) || (kind == K_LW) || (kind == K_SW);
    return e;
  endfunction

  // Expand one instruction into its expected cycle-by-cycle trace.
  task automatic build(input int kind, input int fw, input int mw, input logic taken,
                       input logic mr_idle, input logic [4:0] alu);
    exp_t e;
    q.delete();
    for (int i = 0; i < fw; i++) begin
      e = base(3'd0, kind, alu, 1'b0); e.mrd = 1'b1; q.push_back(e);
    end
    e = base(3'd0, kind, alu, 1'b1); e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    q.push_back(e);
    e = base(3'd1, kind, alu, mr_idle);
    case (kind)
      K_J:     begin e.pcw = 1'b1; e.pcsrc = 2'b10; e.ret = 1'b1; end
      K_JR:    begin e.pcw = 1'b1; e.pcsrc = 2'b11; e.ret = 1'b1; end
      K_NOP:   e.ret = 1'b1;
      K_ILL:   e.ill = 1'b1;
      default: e.ret = 1'b0;
    endcase
    q.push_back(e);
    if (kind == K_J || kind == K_JR || kind == K_NOP || kind == K_ILL) return;
    e = base(3'd2, kind, alu, mr_idle);
    if (kind == K_BR) begin
      e.pcw = taken; e.pcsrc = 2'b01; e.ret = 1'b1; q.push_back(e);
      return;
    end
    q.push_back(e);
    if (kind == K_LW || kind == K_SW) begin
      for (int i = 0; i <= mw; i++) begin
        e = base(3'd3, kind, alu, (i == mw));
        e.iord = 1'b1; e.mrd = (kind == K_LW); e.mwr = (kind == K_SW);
        e.ret = (kind == K_SW) && (i == mw);
        q.push_back(e);
      end
      if (kind == K_SW) return;
    end
    e = base(3'd4, kind, alu, mr_idle);
    e.rw = 1'b1; e.m2r = (kind == K_LW); e.rdst = (kind == K_R1) || (kind == K_R2);
    e.ret = 1'b1;
    q.push_back(e);
  endtask

  task automatic cmp(input exp_t e);
    chk("State", 32'(State), 32'(e.st));
    chk("IRWrite", 32'(IRWrite), 32'(e.irw));
    chk("PCWrite", 32'(PCWrite), 32'(e.pcw));
    chk("PCSrc", 32'(PCSrc), 32'(e.pcsrc));
    chk("IorD", 32'(IorD), 32'(e.iord));
    chk("MemRead", 32'(MemRead), 32'(e.mrd));
    chk("MemWrite", 32'(MemWrite), 32'(e.mwr));
    chk("RegWrite", 32'(RegWrite), 32'(e.rw));
    chk("MemtoReg", 32'(MemtoReg), 32'(e.m2r));
    chk("RegDst", 32'(RegDst), 32'(e.rdst));
    chk("IllegalInstr", 32'(IllegalInstr), 32'(e.ill));
    chk("InstrRetired", 32'(InstrRetired), 32'(e.ret));
    chk("ALUCode", 32'(ALUCode), 32'(e.alu));
    chk("RetiredCount", RetiredCount, model_cnt);
    if (e.st == 3'd2 || e.st == 3'd4) begin
      chk("ALUSrcA", 32'(ALUSrcA), 32'(e.asa));
      chk("ALUSrcB", 32'(ALUSrcB), 32'(e.asb));
    end
  endtask

  // Called just after a rising edge; returns just after the rising edge that ends
  // the instruction, or at the falling edge of cycle n_run when n_run > 0.
  task automatic run_insn(input string nm, input logic [31:0] instr, input int kind,
                          input int fw, input int mw, input logic taken, input logic mr_idle,
                          input logic [4:0] alu, input int exp_len, input int n_run);
    build(kind, fw, mw, taken, mr_idle, alu);
    chk({nm, " latency"}, 32'(q.size()), 32'(exp_len));
    Instruction = instr;
    BranchTaken = taken;
    for (int i = 0; i < q.size(); i++) begin
      MemReady = q[i].mr;
      @(negedge clk);
      cmp(q[i]);
      if (i == n_run - 1) return;
      @(posedge clk);
      #1;
      cyc++;
      if (q[i].ret) model_cnt = model_cnt + 32'd1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    MemReady = 1'b1;
    #12;
    chk("reset State", 32'(State), 32'd0);
    chk("reset MemRead", 32'(MemRead), 32'd0);
    chk("reset IRWrite", 32'(IRWrite), 32'd0);
    chk("reset PCWrite", 32'(PCWrite), 32'd0);
    chk("reset RegWrite", 32'(RegWrite), 32'd0);
    chk("reset MemWrite", 32'(MemWrite), 32'd0);
    chk("reset InstrRetired", 32'(InstrRetired), 32'd0);
    chk("reset RetiredCount", RetiredCount, 32'd0);
    MemReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("MemRead after release", 32'(MemRead), 32'd1);

    run_insn("ADD", 32'h00221820, K_R2, 0, 0, 1'b0, 1'b1, 5'd0, 4, 0);
    chk("ADD RetiredCount", RetiredCount, 32'd1);
    run_insn("LW", 32'h8C240008, K_LW, 0, 2, 1'b0, 1'b0, 5'd0, 7, 0);
    run_insn("BEQ nt", 32'h10220004, K_BR, 0, 0, 1'b0, 1'b0, 5'b01010, 3, 0);
    run_insn("BEQ t", 32'h10220004, K_BR, 0, 0, 1'b1, 1'b1, 5'b01010, 3, 0);
    run_insn("J", 32'h08000010, K_J, 0, 0, 1'b0, 1'b0, 5'd0, 2, 0);
    chk("J back in FETCH", 32'(State), 32'd0);
    run_insn("ILL", 32'hFC000000, K_ILL, 0, 0, 1'b0, 1'b0, 5'd0, 2, 0);
    chk("ILL RetiredCount", RetiredCount, 32'd5);
    run_insn("SW", 32'hAC240008, K_SW, 1, 1, 1'b0, 1'b0, 5'd0, 6, 0);
    run_insn("SLL", 32'h00031080, K_R1, 0, 0, 1'b0, 1'b1, 5'd8, 4, 0);
    run_insn("ADDI", 32'h20420005, K_I, 1, 0, 1'b0, 1'b0, 5'd0, 5, 0);
    run_insn("JR", 32'h03E00008, K_JR, 0, 0, 1'b0, 1'b0, 5'd0, 2, 0);
    run_insn("NOP", 32'h00000000, K_NOP, 0, 0, 1'b0, 1'b0, 5'd8, 2, 0);
    chk("RetiredCount after ten", RetiredCount, 32'd10);

    // SW interrupted by reset during its first memory wait cycle.
    run_insn("SW-rst", 32'hAC240008, K_SW, 0, 3, 1'b0, 1'b0, 5'd0, 7, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst mid-MEM MemWrite", 32'(MemWrite), 32'd0);
    chk("rst mid-MEM MemRead", 32'(MemRead), 32'd0);
    chk("rst mid-MEM State", 32'(State), 32'd0);
    chk("rst mid-MEM RegWrite", 32'(RegWrite), 32'd0);
    chk("rst mid-MEM RetiredCount", RetiredCount, 32'd0);
    model_cnt = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst MemRead", 32'(MemRead), 32'd1);
    chk("post-rst State", 32'(State), 32'd0);

    force dut.retired_count_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_count_q;
    model_cnt = 32'hFFFFFFFF;
    run_insn("NOP wrap", 32'h00000000, K_NOP, 0, 0, 1'b0, 1'b0, 5'd8, 2, 0);
    chk("wrap RetiredCount", RetiredCount, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
